// File: rtl/ternary_pkg.sv
// Shared definitions for the ternary datapath blocks (converter, adder, ...).
// Trit encoding: 2 bits per trit, 00=0, 01=1, 10=2. The code 11 is never produced.
package ternary_pkg;

  localparam logic [1:0] TRIT_0 = 2'b00;
  localparam logic [1:0] TRIT_1 = 2'b01;
  localparam logic [1:0] TRIT_2 = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } conv_state_e;

endpackage

// File: rtl/divide_by_three.sv
// Combinational unsigned divide-by-3 over W bits.
// Ports:
//   dividend  - W-bit unsigned input
//   quotient  - W-bit dividend / 3
//   remainder - dividend mod 3 (0..2), already in trit encoding
module divide_by_three
  import ternary_pkg::*;
#(
  parameter int unsigned W = 6
) (
  input  logic [W-1:0] dividend,
  output logic [W-1:0] quotient,
  output logic [1:0]   remainder
);

  logic [1:0] rem;
  logic [2:0] partial;

  // Restoring long division, MSB first. The running remainder never exceeds 2,
  // so each step only needs a 3-bit compare against 3.
  always_comb begin
    quotient = '0;
    rem      = TRIT_0;
    partial  = '0;
    for (int unsigned i = 0; i < W; i++) begin
      partial = {rem, dividend[W-1-i]};
      if (partial >= 3'd3) begin
        quotient[W-1-i] = 1'b1;
        rem             = 2'(partial - 3'd3);
      end else begin
        rem = partial[1:0];
      end
    end
    remainder = rem;
  end

endmodule

// File: rtl/binary_to_ternary_converter.sv
// Sequential binary -> packed unbalanced-ternary converter, one trit per clock.
// Ports:
//   clk, rstN          - clock, asynchronous active-low reset
//   inValid/inReady    - operand handshake, binIn is the W-bit unsigned operand
//   outValid/outReady  - result handshake
//   tOut               - 2*N-bit packed trits, trit k at [2k+1:2k]
//   overflow           - operand did not fit in N trits (tOut holds binIn mod 3^N)
module binary_to_ternary_converter
  import ternary_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 6
) (
  input  logic           clk,
  input  logic           rstN,
  input  logic           inValid,
  output logic           inReady,
  input  logic [W-1:0]   binIn,
  output logic           outValid,
  input  logic           outReady,
  output logic [2*N-1:0] tOut,
  output logic           overflow
);

  localparam int unsigned      KW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0]    K_LAST = KW'(N - 1);

  conv_state_e    state_q, state_d;
  logic [W-1:0]   q_q, q_d;
  logic [KW-1:0]  k_q, k_d;
  logic [2*N-1:0] tout_q, tout_d;
  logic           ovf_q, ovf_d;

  logic [W-1:0]   div_quot;
  logic [1:0]     div_rem;

  divide_by_three #(.W(W)) u_div (
    .dividend  (q_q),
    .quotient  (div_quot),
    .remainder (div_rem)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      q_q     <= '0;
      k_q     <= '0;
      tout_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      k_q     <= k_d;
      tout_q  <= tout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    k_d     = k_q;
    tout_d  = tout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (inValid) begin
          q_d     = binIn;
          k_d     = '0;
          tout_d  = '0;
          ovf_d   = 1'b0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        tout_d[{k_q, 1'b0} +: 2] = div_rem;
        q_d = div_quot;
        k_d = k_q + KW'(1);
        if (k_q == K_LAST) begin
          // Any quotient left after the top trit means the value needed more trits.
          ovf_d   = (div_quot != '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (outReady) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign inReady  = (state_q == IDLE);
  assign outValid = (state_q == DONE);
  assign tOut     = tout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_binary_to_ternary_converter.sv
// Scoreboard bench for binary_to_ternary_converter: two instances (N=4 and N=3,
// both W=6). Drivers push expected results from an arithmetic reference model;
// per-instance monitors compare whenever a result is presented.
module tb_binary_to_ternary_converter;

  localparam int unsigned W  = 6;
  localparam int unsigned NA = 4;
  localparam int unsigned NB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstN;

  logic           a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_ovf;
  logic [W-1:0]   a_bin;
  logic [2*NA-1:0] a_tout;

  logic           b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ovf;
  logic [W-1:0]   b_bin;
  logic [2*NB-1:0] b_tout;

  binary_to_ternary_converter #(.N(NA), .W(W)) dut_a (
    .clk(clk), .rstN(rstN), .inValid(a_in_valid), .inReady(a_in_ready),
    .binIn(a_bin), .outValid(a_out_valid), .outReady(a_out_ready),
    .tOut(a_tout), .overflow(a_ovf)
  );

  binary_to_ternary_converter #(.N(NB), .W(W)) dut_b (
    .clk(clk), .rstN(rstN), .inValid(b_in_valid), .inReady(b_in_ready),
    .binIn(b_bin), .outValid(b_out_valid), .outReady(b_out_ready),
    .tOut(b_tout), .overflow(b_ovf)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit b_rand_ready = 0;

  // Expected {overflow, trits[7:0]}
  logic [8:0] q_a[$];
  logic [8:0] q_b[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: repeated base-3 digit extraction on an integer.
  function automatic logic [8:0] ref_conv(input int unsigned v, input int unsigned n);
    logic [7:0] t;
    int unsigned r;
    t = '0;
    r = v;
    for (int i = 0; i < int'(n); i++) begin
      t[2*i +: 2] = 2'(r % 3);
      r = r / 3;
    end
    return {(r != 0), t};
  endfunction

  // Monitors
  always @(negedge clk) begin
    if (rstN && a_out_valid) begin
      check("a_in_ready_when_done", 32'(a_in_ready), 32'd0);
      if (q_a.size() == 0) begin
        tests++; fails++;
        $display("FAIL a_unexpected_result: got 0x%0h expected none", {a_ovf, a_tout});
      end else begin
        check("a_result", 32'({a_ovf, a_tout}), 32'(q_a[0]));
        if (a_out_ready) void'(q_a.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rstN && b_out_valid) begin
      check("b_in_ready_when_done", 32'(b_in_ready), 32'd0);
      if (q_b.size() == 0) begin
        tests++; fails++;
        $display("FAIL b_unexpected_result: got 0x%0h expected none", {b_ovf, b_tout});
      end else begin
        check("b_result", 32'({b_ovf, 2'b00, b_tout}), 32'(q_b[0]));
        if (b_out_ready) void'(q_b.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (b_rand_ready) b_out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Offers v to instance `which` (0=A, 1=B); returns the cycle of acceptance.
  task automatic send(input int which, input logic [W-1:0] v, input bit hold, output int acc);
    int n;
    bit done;
    n = 0; done = 0; acc = -1;
    if (which == 0) begin a_in_valid = 1'b1; a_bin = v; end
    else            begin b_in_valid = 1'b1; b_bin = v; end
    while (!done && n < 200) begin
      @(negedge clk);
      if ((which == 0) ? a_in_ready : b_in_ready) begin
        if (which == 0) q_a.push_back(ref_conv(v, NA));
        else            q_b.push_back(ref_conv(v, NB));
        acc  = cyc;
        done = 1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL send_timeout: inst %0d operand %0d not accepted within 200 cycles", which, v);
    end
    if (!hold) begin
      if (which == 0) a_in_valid = 1'b0;
      else            b_in_valid = 1'b0;
    end
  endtask

  task automatic wait_a_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!a_out_valid && n < 50);
  endtask

  int acc, prev, n;
  logic [W-1:0] v;
  logic [2*NA-1:0] held_t;

  initial begin
    rstN = 1'b0;
    a_in_valid = 0; a_bin = '0; a_out_ready = 1'b1;
    b_in_valid = 0; b_bin = '0; b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_in_ready", 32'(a_in_ready), 32'd1);
    check("rst_a_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_a_tout", 32'(a_tout), 32'd0);
    check("rst_a_ovf", 32'(a_ovf), 32'd0);
    check("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    check("rst_b_tout", 32'(b_tout), 32'd0);
    rstN = 1'b1;
    @(posedge clk); #1;

    // Latency and busy behaviour on operand 0
    send(0, 6'd0, 0, acc);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!a_out_valid) check("a_in_ready_busy", 32'(a_in_ready), 32'd0);
    end while (!a_out_valid && n < 50);
    check("a_latency_negedges", 32'(n), 32'(NA + 1));
    @(posedge clk); #1;

    send(0, 6'd63, 0, acc);
    send(0, 6'd5, 0, acc);
    send(1, 6'd40, 0, acc);
    send(1, 6'd26, 0, acc);
    send(1, 6'd63, 0, acc);
    send(1, 6'd27, 0, acc);
    send(1, 6'd0, 0, acc);

    // Backpressure: hold result, inValid pulses must be ignored
    a_out_ready = 1'b0;
    send(0, 6'd17, 0, acc);
    wait_a_valid(n);
    check("bp_valid_seen", 32'(a_out_valid), 32'd1);
    held_t = a_tout;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      a_in_valid = (i != 1);
      a_bin = 6'(i + 7);
      @(negedge clk);
      check("bp_out_valid_held", 32'(a_out_valid), 32'd1);
      check("bp_in_ready_low", 32'(a_in_ready), 32'd0);
      check("bp_tout_stable", 32'(a_tout), 32'(held_t));
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", 32'(a_out_valid), 32'd0);
    check("bp_release_in_ready", 32'(a_in_ready), 32'd1);

    // Asynchronous reset in the middle of a conversion (digit k=2 pending)
    send(0, 6'd50, 0, acc);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("mid_tout_partial_nonzero", 32'(a_tout != '0), 32'd1);
    rstN = 1'b0;
    #1;
    check("async_rst_tout", 32'(a_tout), 32'd0);
    check("async_rst_out_valid", 32'(a_out_valid), 32'd0);
    check("async_rst_in_ready", 32'(a_in_ready), 32'd1);
    check("async_rst_ovf", 32'(a_ovf), 32'd0);
    q_a.delete();
    q_b.delete();
    @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;
    send(0, 6'd17, 0, acc);

    // Back-to-back: inValid and outReady held high
    a_out_ready = 1'b1;
    prev = -1;
    for (int i = 0; i < 6; i++) begin
      v = 6'($urandom_range(0, 63));
      send(0, v, 1, acc);
      if (prev >= 0) check("b2b_interval", 32'(acc - prev), 32'(NA + 2));
      prev = acc;
    end
    a_in_valid = 1'b0;

    // Random traffic on both instances, random backpressure on B
    b_rand_ready = 1;
    fork
      for (int i = 0; i < 20; i++) begin
        int ac;
        send(0, 6'($urandom_range(0, 63)), 0, ac);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
      for (int i = 0; i < 20; i++) begin
        int ac;
        send(1, 6'($urandom_range(0, 63)), 0, ac);
      end
    join
    b_rand_ready = 0;
    b_out_ready = 1'b1;

    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("a_queue_drained", 32'(q_a.size()), 32'd0);
    check("b_queue_drained", 32'(q_b.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
